// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the time-of-day counter.
// All time fields are two-digit packed BCD {tens, units}.
package clock_pkg;
  localparam int NIBBLE_W = 4;

  typedef logic [2*NIBBLE_W-1:0] bcd_t;

  localparam bcd_t SEC_MAX    = 8'h59;
  localparam bcd_t MIN_MAX    = 8'h59;
  localparam bcd_t HOUR24_MAX = 8'h23;
  localparam bcd_t HOUR12_MAX = 8'h12;
  localparam bcd_t HOUR12_MIN = 8'h01;
  localparam bcd_t HOUR12_PM  = 8'h11;

  localparam bcd_t RST_SEC    = 8'h00;
  localparam bcd_t RST_MIN    = 8'h00;
  localparam bcd_t RST_HOUR24 = 8'h00;
  localparam bcd_t RST_HOUR12 = 8'h12;

  function automatic logic bcd_valid(input bcd_t v);
    return (v[2*NIBBLE_W-1:NIBBLE_W] <= 4'd9) && (v[NIBBLE_W-1:0] <= 4'd9);
  endfunction

  // Digit-wise increment; the caller handles the modulus wrap.
  function automatic bcd_t bcd_inc(input bcd_t v);
    if (v[NIBBLE_W-1:0] == 4'd9)
      return {v[2*NIBBLE_W-1:NIBBLE_W] + 4'd1, 4'd0};
    else
      return {v[2*NIBBLE_W-1:NIBBLE_W], v[NIBBLE_W-1:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN..MAX with load and wrap-carry output.
// Priority: rst, then ld, then inc.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd_t MAX = SEC_MAX,
  parameter bcd_t MIN = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       wrap
);

  // Carry is combinational so the next field advances in the same edge.
  assign wrap = inc && !ld && (q == MAX);

  always_ff @(posedge clk) begin
    if (rst)
      q <= MIN;
    else if (ld)
      q <= ld_val;
    else if (inc)
      q <= (q == MAX) ? MIN : bcd_inc(q);
  end

endmodule

// File: rtl/time_of_day_counter.sv
// Seconds/minutes/hours BCD time of day with validated load and midnight
// day_tick; hour field handles both 24 h and 12 h (AM/PM) modes.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter bit HOUR_MODE_24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  input  logic       set_pm,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       day_tick,
  output logic       load_ok,
  output logic       load_err
);

  localparam bcd_t RST_HOUR = HOUR_MODE_24 ? RST_HOUR24 : RST_HOUR12;

  logic step, load_valid, set_ok;
  logic sec_wrap, min_wrap;
  bcd_t hour_next;
  logic pm_next, roll;

  // A load in the same cycle swallows the tick.
  assign step       = tick && run && !load;
  assign load_valid = load && set_ok;

  always_comb begin
    set_ok = bcd_valid(set_hour) && bcd_valid(set_min) && bcd_valid(set_sec)
          && (set_sec <= SEC_MAX) && (set_min <= MIN_MAX);
    if (HOUR_MODE_24)
      set_ok = set_ok && (set_hour <= HOUR24_MAX);
    else
      set_ok = set_ok && (set_hour >= HOUR12_MIN) && (set_hour <= HOUR12_MAX);
  end

  bcd_mod_counter #(.MAX(SEC_MAX), .MIN(RST_SEC)) u_sec (
    .clk(clk), .rst(rst), .inc(step), .ld(load_valid), .ld_val(set_sec),
    .q(sec), .wrap(sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .MIN(RST_MIN)) u_min (
    .clk(clk), .rst(rst), .inc(sec_wrap), .ld(load_valid), .ld_val(set_min),
    .q(min), .wrap(min_wrap)
  );

  // 12 h: 11->12 flips pm, and doing so from PM is the midnight roll.
  always_comb begin
    hour_next = bcd_inc(hour);
    pm_next   = pm;
    roll      = 1'b0;
    if (HOUR_MODE_24) begin
      if (hour == HOUR24_MAX) begin
        hour_next = RST_HOUR24;
        roll      = 1'b1;
      end
    end else begin
      if (hour == HOUR12_MAX) begin
        hour_next = HOUR12_MIN;
      end else if (hour == HOUR12_PM) begin
        pm_next = !pm;
        roll    = pm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour     <= RST_HOUR;
      pm       <= 1'b0;
      day_tick <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day_tick <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (set_ok) begin
          hour    <= set_hour;
          pm      <= HOUR_MODE_24 ? 1'b0 : set_pm;
          load_ok <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end else if (min_wrap) begin
        hour     <= hour_next;
        pm       <= pm_next;
        day_tick <= roll;
      end
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Drives a 24 h and a 12 h instance with shared stimulus; checks both against
// a seconds-of-day reference model plus fixed vectors and 12 h sequences.
module tb_time_of_day_counter;
  logic clk = 1'b0;
  logic rst, tick, run, load, set_pm;
  logic [7:0] set_hour, set_min, set_sec;
  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic pm24, day24, ok24, err24, pm12, day12, ok12, err12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_of_day_counter #(.HOUR_MODE_24(1'b1)) dut24 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .set_pm(set_pm),
    .hour(h24), .min(m24), .sec(s24), .pm(pm24),
    .day_tick(day24), .load_ok(ok24), .load_err(err24)
  );

  time_of_day_counter #(.HOUR_MODE_24(1'b0)) dut12 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .set_pm(set_pm),
    .hour(h12), .min(m12), .sec(s12), .pm(pm12),
    .day_tick(day12), .load_ok(ok12), .load_err(err12)
  );

  // Reference model: time as seconds since midnight.
  typedef struct {
    int t;
    bit day, ok, err;
  } mstate_t;

  mstate_t ms24, ms12;

  function automatic int bcd2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    logic [3:0] tens, units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

  function automatic bit nib_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic mstate_t mstep(input mstate_t st, input bit m24);
    mstate_t n;
    bit valid;
    int hh, hr24;
    n = st;
    n.day = 0; n.ok = 0; n.err = 0;
    if (rst) begin
      n.t = 0;
    end else if (load) begin
      valid = nib_ok(set_hour) && nib_ok(set_min) && nib_ok(set_sec);
      hh = bcd2i(set_hour);
      valid = valid && bcd2i(set_sec) <= 59 && bcd2i(set_min) <= 59;
      valid = valid && (m24 ? (hh <= 23) : (hh >= 1 && hh <= 12));
      if (valid) begin
        hr24 = m24 ? hh : ((hh % 12) + (set_pm ? 12 : 0));
        n.t  = hr24 * 3600 + bcd2i(set_min) * 60 + bcd2i(set_sec);
        n.ok = 1;
      end else begin
        n.err = 1;
      end
    end else if (tick && run) begin
      n.t = (st.t + 1) % 86400;
      n.day = (n.t == 0);
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_hour(input int t, input bit m24);
    int hr;
    hr = t / 3600;
    if (m24) return i2bcd(hr);
    return i2bcd((hr % 12 == 0) ? 12 : hr % 12);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_model();
    chk("m24.hour", 32'(h24), 32'(exp_hour(ms24.t, 1'b1)));
    chk("m24.min",  32'(m24), 32'(i2bcd((ms24.t / 60) % 60)));
    chk("m24.sec",  32'(s24), 32'(i2bcd(ms24.t % 60)));
    chk("m24.pm",   32'(pm24), 32'(0));
    chk("m24.day",  32'(day24), 32'(ms24.day));
    chk("m24.ok",   32'(ok24), 32'(ms24.ok));
    chk("m24.err",  32'(err24), 32'(ms24.err));
    chk("m12.hour", 32'(h12), 32'(exp_hour(ms12.t, 1'b0)));
    chk("m12.min",  32'(m12), 32'(i2bcd((ms12.t / 60) % 60)));
    chk("m12.sec",  32'(s12), 32'(i2bcd(ms12.t % 60)));
    chk("m12.pm",   32'(pm12), 32'(ms12.t >= 43200));
    chk("m12.day",  32'(day12), 32'(ms12.day));
    chk("m12.ok",   32'(ok12), 32'(ms12.ok));
    chk("m12.err",  32'(err12), 32'(ms12.err));
  endtask

  // Inputs change 1 time unit after the edge and are held through the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    ms24 = mstep(ms24, 1'b1);
    ms12 = mstep(ms12, 1'b0);
    check_model();
  endtask

  task automatic drive(input bit r, input bit tk, input bit rn, input bit ld,
                       input logic [7:0] sh, input logic [7:0] sm,
                       input logic [7:0] ss, input bit sp);
    rst = r; tick = tk; run = rn; load = ld;
    set_hour = sh; set_min = sm; set_sec = ss; set_pm = sp;
  endtask

  typedef struct {
    bit rst, tick, run, load;
    logic [7:0] sh, sm, ss;
    logic [7:0] eh, em, es;
    bit eday, eok, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, input bit tk, input bit rn, input bit ld,
                              input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss,
                              input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                              input bit eday, input bit eok, input bit eerr);
    vec_t v;
    v.rst = r; v.tick = tk; v.run = rn; v.load = ld;
    v.sh = sh; v.sm = sm; v.ss = ss;
    v.eh = eh; v.em = em; v.es = es;
    v.eday = eday; v.eok = eok; v.eerr = eerr;
    return v;
  endfunction

  task automatic seq12(input string name, input logic [7:0] sh, input logic [7:0] sm,
                       input logic [7:0] ss, input bit sp, input logic [7:0] eh,
                       input bit epm, input bit eday);
    drive(0, 0, 1, 1, sh, sm, ss, sp);
    step();
    chk({name, ".load_ok"}, 32'(ok12), 32'(1));
    drive(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    step();
    chk({name, ".hour"}, 32'(h12), 32'(eh));
    chk({name, ".minsec"}, 32'({m12, s12}), 32'(16'h0000));
    chk({name, ".pm"}, 32'(pm12), 32'(epm));
    chk({name, ".day"}, 32'(day12), 32'(eday));
  endtask

  initial begin
    ms24 = '{t: 0, day: 0, ok: 0, err: 0};
    ms12 = '{t: 0, day: 0, ok: 0, err: 0};

    //          rst tk rn ld  set h/m/s            expected h/m/s      day ok err
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h23, 8'h59, 8'h58, 8'h23, 8'h59, 8'h58, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h23, 8'h59, 8'h59, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h01, 8'h02, 8'h60, 8'h12, 8'h34, 8'h56, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 8'h24, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 8'h1A, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 8'h05, 8'h5A, 8'h00, 8'h12, 8'h34, 8'h56, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h09, 8'h59, 8'h59, 8'h09, 8'h59, 8'h59, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h59, 8'h00, 8'h00, 8'h59, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h59, 8'h59, 8'h00, 8'h59, 8'h59, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09, 8'h10, 0, 0, 0));

    drive(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    step();
    chk("reset.h12", 32'(h12), 32'(8'h12));
    chk("reset.pm12", 32'(pm12), 32'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].tick, vecs[i].run, vecs[i].load,
            vecs[i].sh, vecs[i].sm, vecs[i].ss, 1'b0);
      step();
      chk($sformatf("vec%0d.time", i), 32'({h24, m24, s24}),
          32'({vecs[i].eh, vecs[i].em, vecs[i].es}));
      chk($sformatf("vec%0d.day", i), 32'(day24), 32'(vecs[i].eday));
      chk($sformatf("vec%0d.ok", i), 32'(ok24), 32'(vecs[i].eok));
      chk($sformatf("vec%0d.err", i), 32'(err24), 32'(vecs[i].eerr));
    end

    seq12("am_to_pm", 8'h11, 8'h59, 8'h59, 1'b0, 8'h12, 1'b1, 1'b0);
    seq12("midnight", 8'h11, 8'h59, 8'h59, 1'b1, 8'h12, 1'b0, 1'b1);
    seq12("12_to_1",  8'h12, 8'h59, 8'h59, 1'b0, 8'h01, 1'b0, 1'b0);
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    step();
    chk("midnight.day_once", 32'(day12), 32'(0));

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] sh, sm, ss;
      int pick;
      pick = int'($urandom_range(0, 3));
      if (pick == 0) begin
        sh = 8'($urandom); sm = 8'($urandom); ss = 8'($urandom);
      end else if (pick == 1) begin
        sh = ($urandom_range(0, 1) == 0) ? 8'h23 : 8'h11;
        sm = 8'h59; ss = i2bcd(int'($urandom_range(50, 59)));
      end else begin
        sh = i2bcd(int'($urandom_range(0, 24))); sm = i2bcd(int'($urandom_range(0, 60)));
        ss = i2bcd(int'($urandom_range(0, 60)));
      end
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0,
            sh, sm, ss, 1'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Consumer end of the one-second strobe. Counts `tick` pulses, each one clock cycle wide and one per second, into a seconds/minutes/hours time of day held as two-digit BCD. It emits a one-cycle `day_tick` on midnight roll-over, which feeds the downstream calendar/century stage. It also accepts a validated load of a new time from the set-time front end.

## Interface
Parameters:
- `HOUR_MODE_24`, default 1: 1 means hours run 00–23; 0 means hours run 01–12 and `pm` toggles at the 11:59:59 → 12:00:00 transition.

Ports:
- `clk` input 1: system clock, same domain as the tick generator.
- `rst` input 1: reset, synchronous, active-high.
- `tick` input 1: one-cycle strobe, one per second; ignored when `run`=0.
- `run` input 1: 1 means count ticks; 0 means hold the current time.
- `load` input 1: one-cycle request to load `set_hour`/`set_min`/`set_sec` (and `set_pm`).
- `set_hour` input 8: BCD hour value to load.
- `set_min` input 8: BCD minute value to load.
- `set_sec` input 8: BCD second value to load.
- `set_pm` input 1: PM flag to load; used only when `HOUR_MODE_24`=0.
- `hour` output 8: current hour, BCD `{tens,units}`.
- `min` output 8: current minute, BCD.
- `sec` output 8: current second, BCD.
- `pm` output 1: PM flag; constant 0 when `HOUR_MODE_24`=1.
- `day_tick` output 1: one-cycle pulse on day roll-over.
- `load_ok` output 1: one-cycle pulse; load accepted.
- `load_err` output 1: one-cycle pulse; load rejected, time unchanged.

## Operation
- All outputs are registered.
- Reset values:
  - 24 h mode: `hour`=00, `min`=00, `sec`=00, `pm`=0, pulses 0.
  - 12 h mode: `hour`=12, `pm`=0.
- Advance, on `tick`=1 and `run`=1:
  - `sec`+1.
  - At 59, `sec` wraps to 00 and carries into `min`.
  - `min` at 59 wraps to 00 and carries into `hour`.
- Hour wrap, 24 h mode: 23 → 00 with carry out, which asserts `day_tick`.
- Hour wrap, 12 h mode:
  - 11 → 12 toggles `pm`.
  - 12 → 01 has no carry.
  - `day_tick` asserts on the 11:59:59 PM → 12:00:00 AM step.
- BCD rule:
  - Units digit counts 0–9; at 9 it returns to 0 and increments tens.
  - No binary intermediate; each digit is 4 bits.
  - Non-BCD nibble codes can never appear on outputs.
- Load validation. A load is valid iff all of the following hold:
  - Every nibble ≤ 9.
  - `set_sec` ≤ 59 and `set_min` ≤ 59.
  - 24 h mode: `set_hour` ≤ 23.
  - 12 h mode: 01 ≤ `set_hour` ≤ 12.
- Valid load: all fields are written together and `load_ok` pulses.
- Invalid load: no field changes and `load_err` pulses.
- Simultaneous `load` and `tick`:
  - `load` has priority and the tick is dropped.
  - The loaded value appears unincremented.
  - `day_tick` does not fire in that cycle.
- `run`=0: ticks are discarded, not queued. Loads are still accepted.
- `rst` in any cycle overrides `load` and `tick`.

## Timing
- Tick latency: `tick` high in cycle N → updated time on outputs in cycle N+1.
- `day_tick` is high in cycle N+1 only, coincident with the 00:00:00 (or 12:00:00 AM) value.
- Load latency: `load` in cycle N → new time or unchanged time in N+1, with `load_ok` or `load_err` high in N+1 only.
- `load` held high for k cycles is processed as k independent loads.
- Back-to-back ticks in consecutive cycles each advance the time by one second. This is not a normal input pattern but must work.
- No combinational path from any input to any output.

## Structure
Shared package `clock_pkg` holds:
- BCD limits: `SEC_MAX`=8'h59, `MIN_MAX`=8'h59, `HOUR24_MAX`=8'h23, `HOUR12_MAX`=8'h12, `HOUR12_MIN`=8'h01.
- Reset time constants.
- The BCD nibble width.

One sub-module, `bcd_mod_counter`:
- Parameters: `MAX`, `MIN`.
- Ports: `clk`, `rst`, `inc`, `ld`, `ld_val[7:0]`, `q[7:0]`, `wrap`.
- Instantiated for seconds and minutes.
- The hour logic, with its 12/24 h and `pm` handling, stays in the top level.

## Test plan
- Reset then 3 ticks → 00:00:03; `day_tick` stays 0.
- 24 h: load 23:59:58 (`load_ok`), then 2 ticks → 23:59:59, then 00:00:00 with `day_tick` high for exactly that one cycle.
- 12 h: load 11:59:59 AM, then tick → 12:00:00 `pm`=1. Load 11:59:59 PM, then tick → 12:00:00 `pm`=0 with `day_tick`=1. Load 12:59:59, then tick → 01:00:00.
- Load 8'h60 into `sec`, and separately `hour`=8'h24 (24 h) and 8'h1A → `load_err`, time unchanged.
- Same-cycle `load` 10:20:30 with `tick` → 10:20:30, no increment, `load_ok`=1.
- `run`=0 while applying 5 ticks → time frozen. `run`=1 then 1 tick → +1 s. Assert `rst` mid-count → 00:00:00 next cycle.
